// File: rtl/grant_lock_pkg.sv
// Shared types and constants for the grant_lock arbiter.
package grant_lock_pkg;

  localparam int REQ_W = 4;
  localparam logic [REQ_W-1:0] NO_GNT = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/grant_lock_if.sv
// Request/grant bundle between requesters (master) and the grant_lock arbiter (slave).
interface grant_lock_if;
  import grant_lock_pkg::*;

  logic [REQ_W-1:0] req;
  logic [REQ_W-1:0] done;
  logic             en;
  logic [REQ_W-1:0] gnt;
  logic             busy;
  logic             timeout;

  modport master (output req, done, en, input gnt, busy, timeout);
  modport slave  (input req, done, en, output gnt, busy, timeout);
endinterface

// File: rtl/grant_lock_prio_sel4.sv
// Fixed-priority picker: highest set bit wins, result is one-hot.
module prio_sel4
  import grant_lock_pkg::*;
(
  input  logic [REQ_W-1:0] vec,
  output logic [REQ_W-1:0] onehot,
  output logic             any
);

  // Ascending scan, so the last (highest) set bit overwrites lower ones.
  always_comb begin
    onehot = NO_GNT;
    for (int i = 0; i < REQ_W; i++) begin
      if (vec[i]) onehot = REQ_W'(1) << i;
    end
    any = |vec;
  end

endmodule

// File: rtl/grant_lock.sv
// Fixed-priority grant holder with bounded hold time, one-cycle gap and
// anti-starvation mask for requesters that were forcibly released.
module grant_lock
  import grant_lock_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic         clock,
  input  logic         reset,
  grant_lock_if.slave  bus
);

  localparam int               CNT_W   = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [REQ_W-1:0] gnt_q, gnt_d;
  logic [REQ_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  logic [REQ_W-1:0] unmasked, cand, sel;
  logic             sel_vld, normal_rel, at_lim;

  // Requesters that timed out step aside only while someone else is asking.
  assign unmasked = bus.req & ~mask_q;
  assign cand     = (|unmasked) ? unmasked : bus.req;

  prio_sel4 u_sel (
    .vec    (cand),
    .onehot (sel),
    .any    (sel_vld)
  );

  // Only the current holder's done/req bits matter; gnt_q is one-hot.
  assign normal_rel = (|(gnt_q & bus.done)) | ~(|(gnt_q & bus.req));
  assign at_lim     = (cnt_q == CNT_LIM);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en && sel_vld) begin
          state_d = HOLD;
          gnt_d   = sel;
          cnt_d   = '0;
          mask_d  = NO_GNT;
        end
      end
      HOLD: begin
        if (normal_rel || at_lim) begin
          state_d = GAP;
          gnt_d   = NO_GNT;
          cnt_d   = '0;
          // A voluntary release on the limit cycle is not a timeout.
          if (!normal_rel) begin
            to_d   = 1'b1;
            mask_d = mask_q | gnt_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= NO_GNT;
      mask_q  <= NO_GNT;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.timeout = to_q;

endmodule

// File: doc/grant_lock.md
GRANT_LOCK -- requirements
Module: grant_lock

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum number of consecutive cycles a grant is held; legal range 2..255.
REQ-002 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester request; bit 3 is highest priority, bit 0 lowest.
REQ-005 The block SHALL have port done, input, 4 bits: per-requester release strobe.
REQ-006 The block SHALL have port en, input, 1 bit: arbitration enable; gates new grants only.
REQ-007 The block SHALL have port gnt, output, 4 bits: registered one-hot grant, or 0000.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, HOLD and GAP.
REQ-011 IDLE: when en=1 and the candidate vector is non-zero, next cycle SHALL have gnt = one-hot of the highest set candidate bit, state HOLD, hold counter 0; req-to-gnt latency is 1 cycle.
REQ-012 Candidate vector SHALL be req & ~mask if that is non-zero, else req.
REQ-013 IDLE with en=0 or candidate = 0: gnt SHALL stay 0000 and state SHALL stay IDLE.
REQ-014 HOLD: gnt SHALL stay constant and the hold counter SHALL increment by 1 each cycle.
REQ-015 HOLD SHALL release, moving to GAP with gnt=0000 next cycle, on any of:
- done[g]=1 for the granted index g
- req[g]=0
- hold counter = MAX_HOLD-1, so the grant is visible exactly MAX_HOLD cycles
REQ-016 A counter-limit release SHALL assert timeout for exactly one cycle, coincident with the first GAP cycle, and SHALL set mask[g].
REQ-017 If done[g] or a req[g] drop coincides with the counter limit, the release SHALL be treated as normal: no timeout, no mask set.
REQ-018 done bits of non-granted requesters SHALL be ignored in every state.
REQ-019 en=0 during HOLD SHALL NOT revoke or shorten the current grant.
REQ-020 GAP SHALL last exactly one cycle with gnt=0000, then the state SHALL be IDLE; a new grant is therefore visible no earlier than 2 cycles after release.
REQ-021 mask SHALL clear to 0000 on the cycle any new grant is issued.
REQ-022 Changes to req during HOLD SHALL NOT affect gnt except through the REQ-015 release rule.
REQ-023 gnt SHALL never have more than one bit set.
REQ-024 busy SHALL be 1 in HOLD and GAP and 0 in IDLE.

Reset
REQ-025 While reset=1 at a clock edge, next state SHALL be: IDLE, gnt=0000, busy=0, timeout=0, hold counter=0, mask=0000.
REQ-026 Reset SHALL take priority over all other inputs.
REQ-027 Reset asserted during HOLD SHALL drop gnt to 0000 at that edge, with no timeout pulse.

Structure
REQ-028 A shared package SHALL hold:
- the state enum (IDLE/HOLD/GAP)
- the width constant REQ_W=4
- the constant NO_GNT=4'b0000
REQ-029 Fixed-priority selection SHALL be one combinational sub-module, prio_sel4: 4-bit in, one-hot 4-bit out, any-valid flag. The FSM, counter and mask SHALL live in grant_lock.
REQ-030 The hold counter width SHALL be $clog2(MAX_HOLD).

Verification
REQ-031 Scenario, normal grant and release:
- stimulus: after reset, req=0101, en=1, done=0001 asserted on the third cycle
- response: gnt=0100 one cycle after req, held until req[2] drops; then one GAP cycle; then gnt=0001
REQ-032 Scenario, enable gating:
- stimulus: en=0, req=1111 for 5 cycles, then en=1
- response: gnt=0000 throughout the en=0 cycles; gnt=1000 one cycle after en rises
REQ-033 Scenario, timeout and mask (MAX_HOLD=4):
- stimulus: req=1001 held constant
- response: gnt=1000 for exactly 4 cycles; timeout=1 in the next cycle with gnt=0000; then gnt=0001; after that releases, 1000 wins again
REQ-034 Scenario, coincident release (MAX_HOLD=4):
- stimulus: done[3]=1 on the 4th grant cycle
- response: timeout stays 0 and mask stays 0000
REQ-035 Scenario, reset mid-HOLD:
- stimulus: reset pulsed while gnt=0010
- response: gnt=0000, busy=0, timeout=0 on the next edge; arbitration resumes normally
REQ-036 Scenario, stray done:
- stimulus: done=0111 while gnt=1000
- response: the grant is unaffected
